mesh_tag_queue: RTL and testbench

- Parametrised in-flight request tracker for the systolic mesh-with-delays datapath.
- Accepts matmul requests (tag + total_rows), queues them in order, and counts result rows emerging from the mesh.
- Attaches the head tag, total_rows and `last` to each row; retires the head entry on its final row.
- Exports all in-flight tags, oldest first, for the controller's hazard checks. Depth, tag width and data width are generic; the previous fixed 6-entry tracker had no row counting or underflow detection.

---
 rtl/mesh_tag_queue_pkg.sv | 26 ++
 rtl/mesh_tag_ring.sv | 80 ++++++++
 rtl/mesh_tag_queue.sv | 131 +++++++++++++
 tb/tb_mesh_tag_queue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_tag_queue_pkg.sv
// Shared types and constants for the mesh in-flight request tracker.
package mesh_tag_queue_pkg;

    localparam int DIM           = 16;
    localparam int ACC_W         = 20;
    localparam int DEFAULT_DEPTH = 6;

    typedef struct packed {
        logic        rob_id_valid;
        logic [5:0]  rob_id;
        logic        is_acc_addr;
        logic        accumulate;
        logic        read_full_acc_row;
        logic [2:0]  norm_cmd;
        logic [10:0] garbage;
        logic        is_garbage;
        logic [13:0] addr_data;
        logic [4:0]  rows;
        logic [4:0]  cols;
    } mesh_tag_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mesh_tag_ring.sv
// Circular buffer of {tag, total_rows} with push/pop, occupancy count and a
// parallel read-out rotated so that slot 0 is always the oldest entry.
module mesh_tag_ring
    import mesh_tag_queue_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int TAG_W  = 40,
    parameter int ROWS_W = 5,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [TAG_W-1:0]       push_tag_i,
    input  logic [ROWS_W-1:0]      push_rows_i,
    input  logic                   pop_i,
    output logic [TAG_W-1:0]       head_tag_o,
    output logic [ROWS_W-1:0]      head_rows_o,
    output logic [CNT_W-1:0]       occupancy_o,
    output logic [DEPTH-1:0]       tags_valid_o,
    output logic [DEPTH*TAG_W-1:0] tags_flat_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [ROWS_W-1:0] rows_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Explicit compare so pointers wrap correctly for non-power-of-2 DEPTH.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        head_d = pop_i  ? wrap_inc(head_q) : head_q;
        tail_d = push_i ? wrap_inc(tail_q) : tail_q;
        cnt_d  = cnt_q;
        if (push_i && !pop_i)
            cnt_d = cnt_q + 1'b1;
        else if (!push_i && pop_i)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            tag_q[tail_q]  <= push_tag_i;
            rows_q[tail_q] <= push_rows_i;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W:0] idx;
            idx = {1'b0, head_q} + (PTR_W + 1)'(i);
            if (idx >= (PTR_W + 1)'(DEPTH))
                idx = idx - (PTR_W + 1)'(DEPTH);
            tags_flat_o[i*TAG_W +: TAG_W] = tag_q[idx[PTR_W-1:0]];
            tags_valid_o[i]               = (CNT_W'(i) < cnt_q);
        end
    end

    assign head_tag_o  = tag_q[head_q];
    assign head_rows_o = rows_q[head_q];
    assign occupancy_o = cnt_q;

endmodule

// File: rtl/mesh_tag_queue.sv
// In-flight matmul request tracker: tags mesh result rows with their owning request.
// Optional perf counters are built when MESH_TAG_QUEUE_PERF_EN is defined.
module mesh_tag_queue
    import mesh_tag_queue_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int TAG_W  = 40,
    parameter int ROWS_W = 5,
    parameter int DATA_W = DIM * ACC_W,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [TAG_W-1:0]       req_tag,
    input  logic [ROWS_W-1:0]      req_total_rows,
    input  logic                   row_valid,
    input  logic [DATA_W-1:0]      row_data,
    output logic                   resp_valid,
    output logic [TAG_W-1:0]       resp_tag,
    output logic [ROWS_W-1:0]      resp_total_rows,
    output logic                   resp_last,
    output logic [DATA_W-1:0]      resp_data,
    output logic [DEPTH-1:0]       tags_valid,
    output logic [DEPTH*TAG_W-1:0] tags_in_progress,
    output logic [CNT_W-1:0]       occupancy,
    output logic                   err_underflow
`ifdef MESH_TAG_QUEUE_PERF_EN
    ,
    output logic [31:0]            perf_full_cycles,
    output logic [31:0]            perf_rows_retired
`endif
);

    logic [CNT_W-1:0]  occ;
    logic [TAG_W-1:0]  head_tag;
    logic [ROWS_W-1:0] head_rows, eff_rows;
    logic [ROWS_W-1:0] row_cnt_q, row_cnt_d;
    logic              push, row_hit, row_last, pop;
    logic              resp_valid_q, resp_last_q, err_q;
    logic [TAG_W-1:0]  resp_tag_q;
    logic [ROWS_W-1:0] resp_rows_q;
    logic [DATA_W-1:0] resp_data_q;

    mesh_tag_ring #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .ROWS_W(ROWS_W),
        .CNT_W (CNT_W)
    ) u_ring (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_tag_i  (req_tag),
        .push_rows_i (req_total_rows),
        .pop_i       (pop),
        .head_tag_o  (head_tag),
        .head_rows_o (head_rows),
        .occupancy_o (occ),
        .tags_valid_o(tags_valid),
        .tags_flat_o (tags_in_progress)
    );

    // Ready depends only on registered occupancy; a same-cycle pop never frees a full queue.
    assign req_ready = (occ != CNT_W'(DEPTH));
    assign push      = req_valid && req_ready;
    assign row_hit   = row_valid && (occ != '0);
    assign eff_rows  = (head_rows == '0) ? ROWS_W'(1) : head_rows;
    assign row_last  = (row_cnt_q == eff_rows - 1'b1);
    assign pop       = row_hit && row_last;

    always_comb begin
        row_cnt_d = row_cnt_q;
        if (row_hit)
            row_cnt_d = row_last ? '0 : row_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            row_cnt_q    <= row_cnt_d;
            resp_valid_q <= row_hit;
            resp_last_q  <= pop;
            err_q        <= err_q | (row_valid && (occ == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (row_hit) begin
            resp_tag_q  <= head_tag;
            resp_rows_q <= head_rows;
            resp_data_q <= row_data;
        end
    end

    assign resp_valid      = resp_valid_q;
    assign resp_last       = resp_last_q;
    assign resp_tag        = resp_tag_q;
    assign resp_total_rows = resp_rows_q;
    assign resp_data       = resp_data_q;
    assign occupancy       = occ;
    assign err_underflow   = err_q;

    a_rows_nonzero: assert property (@(posedge clk) disable iff (rst)
        push |-> (req_total_rows != '0));

`ifdef MESH_TAG_QUEUE_PERF_EN
    logic [31:0] perf_full_q, perf_rows_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_q <= '0;
            perf_rows_q <= '0;
        end else begin
            if (req_valid && !req_ready)
                perf_full_q <= sat_inc32(perf_full_q);
            if (resp_valid_q)
                perf_rows_q <= sat_inc32(perf_rows_q);
        end
    end

    assign perf_full_cycles  = perf_full_q;
    assign perf_rows_retired = perf_rows_q;
`endif

endmodule

// File: tb/tb_mesh_tag_queue.sv
// Scoreboard bench for mesh_tag_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_mesh_tag_queue;

    localparam int DEPTH  = 6;
    localparam int TAG_W  = 40;
    localparam int ROWS_W = 5;
    localparam int DATA_W = 320;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   req_valid;
    logic                   req_ready;
    logic [TAG_W-1:0]       req_tag;
    logic [ROWS_W-1:0]      req_total_rows;
    logic                   row_valid;
    logic [DATA_W-1:0]      row_data;
    logic                   resp_valid;
    logic [TAG_W-1:0]       resp_tag;
    logic [ROWS_W-1:0]      resp_total_rows;
    logic                   resp_last;
    logic [DATA_W-1:0]      resp_data;
    logic [DEPTH-1:0]       tags_valid;
    logic [DEPTH*TAG_W-1:0] tags_in_progress;
    logic [CNT_W-1:0]       occupancy;
    logic                   err_underflow;
`ifdef MESH_TAG_QUEUE_PERF_EN
    logic [31:0]            perf_full_cycles;
    logic [31:0]            perf_rows_retired;
`endif

    always #5 clk = ~clk;

    mesh_tag_queue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .ROWS_W(ROWS_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_tag         (req_tag),
        .req_total_rows  (req_total_rows),
        .row_valid       (row_valid),
        .row_data        (row_data),
        .resp_valid      (resp_valid),
        .resp_tag        (resp_tag),
        .resp_total_rows (resp_total_rows),
        .resp_last       (resp_last),
        .resp_data       (resp_data),
        .tags_valid      (tags_valid),
        .tags_in_progress(tags_in_progress),
        .occupancy       (occupancy),
        .err_underflow   (err_underflow)
`ifdef MESH_TAG_QUEUE_PERF_EN
        ,
        .perf_full_cycles (perf_full_cycles),
        .perf_rows_retired(perf_rows_retired)
`endif
    );

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [ROWS_W-1:0] rows;
    } entry_t;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [ROWS_W-1:0] rows;
        logic              last;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    entry_t mq[$];
    exp_t   sb[$];
    int     m_idx   = 0;
    bit     m_err   = 1'b0;
    bit     m_resp  = 1'b0;
    int     checks  = 0;
    int     failures = 0;
    int     cyc     = 0;
    exp_t   mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [TAG_W-1:0] rtag();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[TAG_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] rdata();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Called just after a falling edge: check state, drive inputs, advance model.
    task automatic step(input bit rs, input bit rv, input logic [ROWS_W-1:0] rr, input bit rw);
        logic [DEPTH-1:0] tv;
        bit               do_push;
        int               total;
        exp_t             e;
        entry_t           n;
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("req_ready", 64'(req_ready), 64'(mq.size() != DEPTH));
        chk("err_underflow", 64'(err_underflow), 64'(m_err));
        chk("resp_valid", 64'(resp_valid), 64'(m_resp));
        for (int i = 0; i < DEPTH; i++) tv[i] = (i < mq.size());
        chk("tags_valid", 64'(tags_valid), 64'(tv));
        for (int i = 0; i < mq.size(); i++)
            chk("tag_slot", 64'(tags_in_progress[i*TAG_W +: TAG_W]), 64'(mq[i].tag));

        rst            = rs;
        req_valid      = rv;
        req_tag        = rtag();
        req_total_rows = rr;
        row_valid      = rw;
        row_data       = rdata();

        m_resp = 1'b0;
        if (rs) begin
            mq.delete();
            m_idx = 0;
            m_err = 1'b0;
        end else begin
            do_push = rv && (mq.size() != DEPTH);
            if (rw) begin
                if (mq.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    total  = (mq[0].rows == 0) ? 1 : int'(mq[0].rows);
                    e.tag  = mq[0].tag;
                    e.rows = mq[0].rows;
                    e.last = (m_idx + 1 == total);
                    e.data = row_data;
                    e.due  = cyc + 1;
                    sb.push_back(e);
                    m_resp = 1'b1;
                    if (e.last) begin
                        void'(mq.pop_front());
                        m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
            if (do_push) begin
                n.tag  = req_tag;
                n.rows = rr;
                mq.push_back(n);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd1, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && mq.size() > 0; i++) step(1'b0, 1'b0, 5'd1, 1'b1);
        chk("drain_empty", 64'(mq.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected: resp_valid=1 with no row outstanding (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_tag", 64'(resp_tag), 64'(mon_e.tag));
                chk("resp_total_rows", 64'(resp_total_rows), 64'(mon_e.rows));
                chk("resp_last", 64'(resp_last), 64'(mon_e.last));
                checks++;
                if (resp_data !== mon_e.data) begin
                    failures++;
                    $display("FAIL resp_data: got %0h expected %0h", resp_data, mon_e.data);
                end
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            checks++;
            failures++;
            $display("FAIL resp_missing: resp_valid=%b expected 1 (cycle %0d)", resp_valid, cyc);
            void'(sb.pop_front());
        end
    end

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_tag        = '0;
        req_total_rows = 5'd1;
        row_valid      = 1'b0;
        row_data       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        step(1'b1, 1'b0, 5'd1, 1'b0);

        // single request of three rows
        step(1'b0, 1'b1, 5'd3, 1'b0);
        repeat (3) step(1'b0, 1'b0, 5'd1, 1'b1);
        idle(2);

        // fill to full, hold a 7th request, pop at full
        repeat (DEPTH) step(1'b0, 1'b1, 5'd2, 1'b0);
        repeat (2) step(1'b0, 1'b1, 5'd2, 1'b0);
        step(1'b0, 1'b1, 5'd2, 1'b1);
        step(1'b0, 1'b1, 5'd2, 1'b1);
        step(1'b0, 1'b1, 5'd3, 1'b0);
        drain();
        idle(1);

        // push and final row together at occupancy DEPTH-1
        repeat (DEPTH - 1) step(1'b0, 1'b1, 5'd1, 1'b0);
        step(1'b0, 1'b1, 5'd1, 1'b1);
        idle(1);
        drain();
        idle(1);

        // underflow on an empty queue
        step(1'b0, 1'b0, 5'd1, 1'b1);
        idle(1);

        // reset mid-operation with rows in flight
        repeat (3) step(1'b0, 1'b1, 5'd4, 1'b0);
        repeat (2) step(1'b0, 1'b0, 5'd1, 1'b1);
        step(1'b1, 1'b0, 5'd1, 1'b0);
        idle(1);

        // push and row in the same cycle on an empty queue
        step(1'b0, 1'b1, 5'd2, 1'b1);
        drain();
        idle(1);

        // total_rows 1,16,1 with back-to-back rows
        step(1'b1, 1'b0, 5'd1, 1'b0);
        step(1'b0, 1'b1, 5'd1, 1'b0);
        step(1'b0, 1'b1, 5'd16, 1'b0);
        step(1'b0, 1'b1, 5'd1, 1'b0);
        repeat (18) step(1'b0, 1'b0, 5'd1, 1'b1);
        idle(2);
`ifdef MESH_TAG_QUEUE_PERF_EN
        chk("perf_rows_retired", 64'(perf_rows_retired), 64'd18);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 299) == 0), $urandom_range(0, 1) == 1,
                 ROWS_W'($urandom_range(1, 6)), $urandom_range(0, 99) < 45);
        idle(3);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
